// File: rtl/pwm_bank_shadowed_if.sv
// Register-file side bundle of the shadowed PWM bank: enables, prescale,
// duty write port, force strobe, and the pin-side outputs.
interface pwm_bank_shadowed_if #(
  parameter int NUM_CH         = 16,
  parameter int CNT_WIDTH      = 8,
  parameter int PRESCALE_WIDTH = 8,
  parameter int ADDR_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic [NUM_CH-1:0]         en_out;
  logic [NUM_CH-1:0]         en_pwm;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic                      duty_we;
  logic [ADDR_W-1:0]         duty_addr;
  logic [CNT_WIDTH-1:0]      duty_wdata;
  logic                      force_update;
  logic [NUM_CH-1:0]         pwm_out;
  logic                      period_start;

  modport master (
    output en_out, en_pwm, prescale, duty_we, duty_addr, duty_wdata, force_update,
    input  pwm_out, period_start
  );

  modport slave (
    input  en_out, en_pwm, prescale, duty_we, duty_addr, duty_wdata, force_update,
    output pwm_out, period_start
  );
endinterface

// File: rtl/pwm_bank_shadowed.sv
// NUM_CH-channel PWM bank with double-buffered duty registers that reload only
// at period boundaries (or on force_update), plus a programmable tick prescaler.
module pwm_bank_shadowed #(
  parameter int NUM_CH         = 16,
  parameter int CNT_WIDTH      = 8,
  parameter int PRESCALE_WIDTH = 8,
  parameter int ADDR_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input logic                clk,
  input logic                rst_n,
  pwm_bank_shadowed_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = {{(CNT_WIDTH-1){1'b1}}, 1'b0};

  logic [PRESCALE_WIDTH-1:0]           pcnt_r;
  logic [CNT_WIDTH-1:0]                cnt_r;
  logic [NUM_CH-1:0][CNT_WIDTH-1:0]    pending_r;
  logic [NUM_CH-1:0][CNT_WIDTH-1:0]    active_r;
  logic [NUM_CH-1:0]                   pwm_out_r;
  logic                                start_pend_r;
  logic                                period_start_r;

  logic                                tick_s;
  logic                                boundary_s;
  logic                                addr_ok_s;
  logic [NUM_CH-1:0]                   wr_sel_s;
  logic [NUM_CH-1:0][CNT_WIDTH-1:0]    load_val_s;
  logic [NUM_CH-1:0]                   next_out_s;

  // >= compare so a prescale lowered below pcnt ticks immediately
  assign tick_s     = (pcnt_r >= bus.prescale);
  assign boundary_s = tick_s && (cnt_r == CNT_LAST);
  assign addr_ok_s  = (32'(bus.duty_addr) < 32'(NUM_CH));

  // Write decode, forwarded force-load values and next pin levels
  always_comb begin
    wr_sel_s   = '0;
    load_val_s = pending_r;
    next_out_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.duty_we && addr_ok_s && (bus.duty_addr == ADDR_W'(i))) begin
        wr_sel_s[i]   = 1'b1;
        load_val_s[i] = bus.duty_wdata;
      end else begin
        wr_sel_s[i]   = 1'b0;
        load_val_s[i] = pending_r[i];
      end
      if (!bus.en_out[i]) begin
        next_out_s[i] = 1'b0;
      end else if (!bus.en_pwm[i]) begin
        next_out_s[i] = 1'b1;
      end else begin
        next_out_s[i] = (cnt_r < active_r[i]);
      end
    end
  end

  // Prescaler, period counter and period-start pipeline stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_r       <= '0;
      cnt_r        <= '0;
      start_pend_r <= 1'b0;
    end else if (bus.force_update) begin
      pcnt_r       <= '0;
      cnt_r        <= '0;
      start_pend_r <= 1'b1;
    end else begin
      start_pend_r <= boundary_s;
      if (tick_s) begin
        pcnt_r <= '0;
        cnt_r  <= boundary_s ? '0 : cnt_r + CNT_WIDTH'(1);
      end else begin
        pcnt_r <= pcnt_r + PRESCALE_WIDTH'(1);
      end
    end
  end

  // Pending duty registers; out-of-range addresses never match a channel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_sel_s[i]) begin
          pending_r[i] <= bus.duty_wdata;
        end
      end
    end
  end

  // Active duty registers: natural boundary loads pre-write pending values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_r <= '0;
    end else if (bus.force_update) begin
      active_r <= load_val_s;
    end else if (boundary_s) begin
      active_r <= pending_r;
    end
  end

  // Registered pin outputs, aligned with the period_start pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_out_r      <= '0;
      period_start_r <= 1'b0;
    end else begin
      pwm_out_r      <= next_out_s;
      period_start_r <= start_pend_r;
    end
  end

  assign bus.pwm_out      = pwm_out_r;
  assign bus.period_start = period_start_r;

endmodule

// File: tb/tb_pwm_bank_shadowed.sv
// Randomised and directed bench for pwm_bank_shadowed against a clock-level
// behavioural model of the PWM bank.
module tb_pwm_bank_shadowed;
  localparam int NUM_CH         = 12;
  localparam int CNT_WIDTH      = 8;
  localparam int PRESCALE_WIDTH = 8;
  localparam int ADDR_W         = 4;
  localparam int MAX            = (1 << CNT_WIDTH) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  pwm_bank_shadowed_if #(.NUM_CH(NUM_CH), .CNT_WIDTH(CNT_WIDTH),
    .PRESCALE_WIDTH(PRESCALE_WIDTH), .ADDR_W(ADDR_W)) bus ();

  pwm_bank_shadowed #(.NUM_CH(NUM_CH), .CNT_WIDTH(CNT_WIDTH),
    .PRESCALE_WIDTH(PRESCALE_WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Behavioural model: tick position, period position, duty buffers, predicted pins
  int                m_pcnt;
  int                m_cnt;
  int                m_pend [NUM_CH];
  int                m_act  [NUM_CH];
  logic [NUM_CH-1:0] m_out;
  logic              m_ps;
  bit                m_start_due;

  function automatic void model_reset();
    m_pcnt = 0; m_cnt = 0; m_out = '0; m_ps = 1'b0; m_start_due = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin m_pend[i] = 0; m_act[i] = 0; end
  endfunction

  function automatic bit next_is_boundary();
    return (m_pcnt >= int'(bus.prescale)) && (m_cnt == MAX - 1);
  endfunction

  function automatic void model_edge();
    bit tick, wr;
    int wa;
    for (int i = 0; i < NUM_CH; i++)
      m_out[i] = bus.en_out[i] ? (bus.en_pwm[i] ? (m_cnt < m_act[i]) : 1'b1) : 1'b0;
    m_ps = m_start_due;
    wa = int'(bus.duty_addr);
    wr = bus.duty_we && (wa < NUM_CH);
    if (bus.force_update) begin
      m_act = m_pend;
      if (wr) m_act[wa] = int'(bus.duty_wdata);
      m_cnt = 0; m_pcnt = 0; m_start_due = 1'b1;
    end else begin
      tick = (m_pcnt >= int'(bus.prescale));
      m_start_due = tick && (m_cnt == MAX - 1);
      if (m_start_due) m_act = m_pend;
      if (tick) begin m_pcnt = 0; m_cnt = (m_cnt + 1) % MAX; end
      else m_pcnt = m_pcnt + 1;
    end
    if (wr) m_pend[wa] = int'(bus.duty_wdata);
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic write_duty(input int ch, input int val, input bit frc);
    bus.duty_we = 1'b1; bus.duty_addr = ADDR_W'(ch); bus.duty_wdata = CNT_WIDTH'(val);
    bus.force_update = frc;
    cycle();
    bus.duty_we = 1'b0; bus.force_update = 1'b0;
  endtask

  task automatic wait_start(input int budget, output bit found);
    found = 1'b0;
    for (int k = 0; k < budget && !found; k++) begin
      cycle();
      if (bus.period_start === 1'b1) found = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; #3; rst_n = 1'b0; #1;
    model_reset();
    checks++;
    if (bus.pwm_out !== '0 || bus.period_start !== 1'b0) begin
      failures++; $display("FAIL reset_state actual=%h/%b expected=0/0", bus.pwm_out, bus.period_start);
    end
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    cycle();
    bus.en_out = '1;
    cycle();
    checks++;
    if (bus.pwm_out !== {NUM_CH{1'b1}} || bus.pwm_out !== m_out) begin
      failures++; $display("FAIL static_high actual=%h expected=%h", bus.pwm_out, {NUM_CH{1'b1}});
    end
    bus.en_out = '0;
    cycle();
    checks++;
    if (bus.pwm_out !== '0) begin
      failures++; $display("FAIL force_low actual=%h expected=0", bus.pwm_out);
    end
  endtask

  task automatic test_duty_ch3();
    int duties [3] = '{128, 0, 255};
    int highs;
    bit found;
    bus.prescale = '0;
    write_duty(3, 128, 1'b0);
    wait_start(600, found);
    checks++;
    if (!found) begin failures++; $display("FAIL ch3_first_start actual=0 expected=1"); end
    bus.en_out[3] = 1'b1; bus.en_pwm[3] = 1'b1;
    for (int d = 0; d < 3; d++) begin
      write_duty(3, duties[d], 1'b0);
      wait_start(600, found);
      checks++;
      if (!found) begin failures++; $display("FAIL ch3_start_%0d actual=0 expected=1", d); end
      highs = 0;
      for (int k = 0; k < MAX; k++) begin
        if (k > 0) cycle();
        highs += int'(bus.pwm_out[3]);
        checks++;
        if (bus.pwm_out !== m_out || bus.period_start !== m_ps) begin
          failures++; $display("FAIL ch3_model actual=%h/%b expected=%h/%b", bus.pwm_out, bus.period_start, m_out, m_ps);
        end
      end
      checks++;
      if (highs != duties[d]) begin
        failures++; $display("FAIL ch3_high_count actual=%0d expected=%0d", highs, duties[d]);
      end
    end
  endtask

  task automatic test_glitch_free();
    int highs, edges, exp_h [2], exp_e [2];
    logic prev;
    bit found;
    exp_h = '{64, 200}; exp_e = '{1, 2};
    bus.en_out[0] = 1'b1; bus.en_pwm[0] = 1'b1;
    write_duty(0, 64, 1'b0);
    wait_start(600, found);
    checks++;
    if (!found) begin failures++; $display("FAIL glitch_start actual=0 expected=1"); end
    prev = 1'b0;
    for (int p = 0; p < 2; p++) begin
      highs = 0; edges = 0;
      for (int k = 0; k < MAX; k++) begin
        if (p > 0 || k > 0) begin
          if (p == 0 && k == 100) write_duty(0, 200, 1'b0);
          else cycle();
        end
        highs += int'(bus.pwm_out[0]);
        if (bus.pwm_out[0] !== prev && (p > 0 || k > 0)) edges++;
        prev = bus.pwm_out[0];
        checks++;
        if (bus.pwm_out !== m_out || bus.period_start !== m_ps) begin
          failures++; $display("FAIL glitch_model actual=%h/%b expected=%h/%b", bus.pwm_out, bus.period_start, m_out, m_ps);
        end
      end
      checks++;
      if (highs != exp_h[p] || edges != exp_e[p]) begin
        failures++; $display("FAIL glitch_period%0d actual=%0d/%0d expected=%0d/%0d", p, highs, edges, exp_h[p], exp_e[p]);
      end
    end
  endtask

  task automatic measure_after_load(input string name, input int exp_high);
    int highs, starts;
    highs = 0; starts = 0;
    for (int k = 0; k < MAX; k++) begin
      cycle();
      if (k == 0) begin
        checks++;
        if (bus.period_start !== 1'b1) begin
          failures++; $display("FAIL %s_start actual=%b expected=1", name, bus.period_start);
        end
      end
      highs += int'(bus.pwm_out[0]);
      starts += int'(bus.period_start);
    end
    checks++;
    if (highs != exp_high || starts != 1) begin
      failures++; $display("FAIL %s_period actual=%0d/%0d expected=%0d/1", name, highs, starts, exp_high);
    end
  endtask

  task automatic test_boundary_write();
    int guard;
    guard = 0;
    while (!next_is_boundary() && guard < 600) begin cycle(); guard++; end
    checks++;
    if (!next_is_boundary()) begin failures++; $display("FAIL bnd_reach actual=0 expected=1"); end
    write_duty(0, 32, 1'b0);
    measure_after_load("bnd_old", 200);
    measure_after_load("bnd_new", 32);
    repeat (37) cycle();
    write_duty(0, 90, 1'b1);
    measure_after_load("force_mid", 90);
    guard = 0;
    while (!next_is_boundary() && guard < 600) begin cycle(); guard++; end
    checks++;
    if (!next_is_boundary()) begin failures++; $display("FAIL bnd_reach2 actual=0 expected=1"); end
    write_duty(0, 10, 1'b1);
    measure_after_load("force_at_bnd", 10);
  endtask

  task automatic test_prescale();
    int n, guard;
    bit found;
    bus.prescale = 8'd3;
    for (int r = 0; r < 2; r++) begin
      wait_start(2200, found);
      n = 0; found = 1'b0;
      while (!found && n < 1100) begin
        cycle(); n++;
        if (bus.period_start === 1'b1) found = 1'b1;
        checks++;
        if (bus.pwm_out !== m_out || bus.period_start !== m_ps) begin
          failures++; $display("FAIL pre_model actual=%h/%b expected=%h/%b", bus.pwm_out, bus.period_start, m_out, m_ps);
        end
      end
      checks++;
      if (n != (r == 0 ? 1020 : 765)) begin
        failures++; $display("FAIL pre_spacing%0d actual=%0d expected=%0d", r, n, (r == 0 ? 1020 : 765));
      end
      if (r == 0) begin
        bus.prescale = 8'd200;
        guard = 0;
        while (m_pcnt != 150 && guard < 400) begin cycle(); guard++; end
        bus.prescale = 8'd2;
        cycle();
        checks++;
        if (dut.pcnt_r !== 8'd0 || guard >= 400) begin
          failures++; $display("FAIL pre_lower actual=%0d expected=0", dut.pcnt_r);
        end
      end
    end
  endtask

  task automatic test_bad_addr();
    int highs [NUM_CH];
    bus.prescale = '0; bus.en_out = '1; bus.en_pwm = '1;
    write_duty(NUM_CH, 77, 1'b0);
    write_duty(15, 99, 1'b0);
    bus.force_update = 1'b1; cycle(); bus.force_update = 1'b0;
    for (int i = 0; i < NUM_CH; i++) highs[i] = 0;
    for (int k = 0; k < MAX; k++) begin
      cycle();
      for (int i = 0; i < NUM_CH; i++) highs[i] += int'(bus.pwm_out[i]);
    end
    for (int i = 0; i < NUM_CH; i++) begin
      checks++;
      if (highs[i] != m_act[i]) begin
        failures++; $display("FAIL bad_addr_ch%0d actual=%0d expected=%0d", i, highs[i], m_act[i]);
      end
    end
    checks++;
    if (highs[0] != 10 || highs[3] != 255) begin
      failures++; $display("FAIL bad_addr_known actual=%0d/%0d expected=10/255", highs[0], highs[3]);
    end
  endtask

  task automatic test_reset_mid();
    int bad, highs;
    bit found;
    @(posedge clk); #2; rst_n = 1'b0; #1;
    checks++;
    if (bus.pwm_out !== '0 || bus.period_start !== 1'b0) begin
      failures++; $display("FAIL rst_async actual=%h expected=0", bus.pwm_out);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 600; k++) begin
      cycle();
      if (bus.pwm_out !== '0) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL rst_stay_low actual=%0d expected=0", bad); end
    write_duty(1, 50, 1'b0);
    wait_start(600, found);
    highs = 0;
    for (int k = 0; k < MAX; k++) begin
      if (k > 0) cycle();
      highs += int'(bus.pwm_out[1]);
    end
    checks++;
    if (!found || highs != 50) begin
      failures++; $display("FAIL rst_reload actual=%0d expected=50", highs);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 49) == 0) bus.en_out = NUM_CH'($urandom);
      if ($urandom_range(0, 49) == 0) bus.en_pwm = NUM_CH'($urandom);
      if ($urandom_range(0, 299) == 0) bus.prescale = PRESCALE_WIDTH'($urandom_range(0, 2));
      bus.duty_we      = ($urandom_range(0, 9) == 0);
      bus.duty_addr    = ADDR_W'($urandom_range(0, 15));
      bus.duty_wdata   = CNT_WIDTH'($urandom);
      bus.force_update = ($urandom_range(0, 199) == 0);
      cycle();
      checks++;
      if (bus.pwm_out !== m_out || bus.period_start !== m_ps) begin
        failures++; $display("FAIL rand_model actual=%h/%b expected=%h/%b", bus.pwm_out, bus.period_start, m_out, m_ps);
      end
    end
    bus.duty_we = 1'b0; bus.force_update = 1'b0;
  endtask

  initial begin
    bus.en_out = '0; bus.en_pwm = '0; bus.prescale = '0; bus.duty_we = 1'b0;
    bus.duty_addr = '0; bus.duty_wdata = '0; bus.force_update = 1'b0;
    model_reset();
    test_reset();
    test_duty_ch3();
    test_glitch_free();
    test_boundary_write();
    test_prescale();
    test_bad_addr();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pwm_bank_shadowed.md
Name: pwm_bank_shadowed

Overview:
- Parametrised successor to the fixed 16-output PWM peripheral. NUM_CH channels, each with its own duty register.
- Duty writes are double-buffered (pending → active) and only take effect at period boundaries, so no runt or glitch pulses occur.
- A programmable prescaler sets the PWM frequency.
- Sits between the SPI register file (enables, prescale, duty write strobes) and the uo_out/uio_out pins.

Parameters:
- NUM_CH, 16, number of PWM channels (1..32).
- CNT_WIDTH, 8, duty/period counter width; period = 2^CNT_WIDTH-1 ticks.
- PRESCALE_WIDTH, 8, width of the prescale divider value.
- ADDR_W, $clog2(NUM_CH) (min 1), duty write address width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en_out  in  NUM_CH  per-channel output enable (1 = drive, 0 = force low).
- en_pwm  in  NUM_CH  per-channel mode (1 = PWM, 0 = static high when enabled).
- prescale  in  PRESCALE_WIDTH  tick divider; one tick every prescale+1 clocks.
- duty_we  in  1  duty write strobe, single cycle.
- duty_addr  in  ADDR_W  channel index for write.
- duty_wdata  in  CNT_WIDTH  duty value.
- force_update  in  1  single-cycle: copy all pending to active, restart period.
- pwm_out  out  NUM_CH  registered channel outputs.
- period_start  out  1  one-clock pulse on the first clock of each period.

Behaviour:
- Reset (async, rst_n=0):
  - pwm_out=0, period_start=0.
  - Prescale counter, period counter, all pending and all active duty registers = 0.
- Prescaler:
  - pcnt increments each clk.
  - When pcnt >= prescale: tick=1 and pcnt←0.
  - prescale=0 → tick every clk.
  - Lowering prescale below the current pcnt gives a tick on the next clk (>= compare); no lockup.
- Period counter:
  - MAX = 2^CNT_WIDTH-1. cnt advances on tick, counting 0..MAX-1.
  - At cnt=MAX-1 with tick, cnt←0; this is a boundary.
- Duty writes:
  - duty_we=1 with duty_addr<NUM_CH → pending[duty_addr]←duty_wdata next clk.
  - duty_addr>=NUM_CH is ignored with no side effects.
- Shadow load:
  - At a boundary, active[i]←pending[i] for all i, using pending values before any same-cycle write.
  - A write coincident with a boundary therefore takes effect at the following boundary.
- force_update:
  - Next clk: active←pending (including a same-cycle write, which is forwarded), cnt←0, pcnt←0.
  - period_start pulses.
  - force_update has priority over a coincident natural boundary.
- Compare:
  - raw[i] = (cnt < active[i]).
  - duty=0 → always low; duty=MAX → always high; duty=d → high for d of MAX ticks.
- Output select (registered, 1 clk latency from cnt/active/en_* to pwm_out):
  - en_out[i]=0 → 0.
  - en_out[i]=1, en_pwm[i]=0 → 1.
  - en_out[i]=1, en_pwm[i]=1 → raw[i].
- Enable changes are asynchronous to the period: they apply on the next clk and are not shadowed.
- period_start: registered; high for exactly one clk, coincident with the first clk on which pwm_out reflects cnt=0 of the new period.
- Reset mid-period: all state clears immediately. After release, cnt starts at 0 with active=0, so outputs stay low until enabled as static high or until a boundary/force_update loads non-zero duty.

Test Plan:
- Reset, then en_out=all 1, en_pwm=0 → pwm_out=all 1 one clk later; en_out=0 → all 0.
- prescale=0, write ch3 duty=128, wait for period_start, en_out/en_pwm ch3=1:
  - ch3 high 128 of 255 clks per period.
  - duty=0 → constant 0; duty=255 → constant 1.
- Glitch-free update: ch0 duty=64 running, write 200 at cnt=100 → current period keeps 64-clk high; next period has 200-clk high; no extra edges.
- Write coincident with boundary → old pending applies this period, new value the next. Same write plus force_update → new value immediately, cnt=0, period_start pulses once.
- prescale=3 → period 1020 clks; period_start spacing 1020. Change prescale 200→2 while pcnt=150 → tick on next clk, no stall.
- duty_addr=NUM_CH write is ignored. Assert rst_n low mid-period → pwm_out=0 asynchronously; after release, outputs stay low with en_pwm=1 until a new duty is loaded.
